// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS instructions into 32-bit words and
// writes them to instruction memory at consecutive word addresses.
module instr_encoder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    input  logic              im_ack,
    output logic              full,
    output logic              illegal,
    output logic [ADDR_W:0]   wr_count,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {StIdle, StWrite, StFull} state_e;

    localparam logic [ADDR_W:0] DepthVal = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PtrOne   = (ADDR_W + 1)'(1);

    state_e          state_q, state_d;
    logic [ADDR_W:0] ptr_q, ptr_d, ptr_inc;
    logic [31:0]     wdata_q, wdata_d;
    logic            illegal_q, illegal_d;
    logic [7:0]      err_q, err_d;
    logic            legal;
    logic [31:0]     enc;

    // Encode the presented request; unused fields are forced to zero.
    always_comb begin
        legal = 1'b1;
        enc   = 32'h0;
        case (in_mnem)
            5'd0:  enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};      // ADDU
            5'd1:  enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};      // SUBU
            5'd2:  enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};      // SLT
            5'd3:  enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};      // AND
            5'd4:  enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};      // OR
            5'd5:  enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h27};      // NOR
            5'd6:  enc = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h02};   // SRL
            5'd7:  enc = {6'h00, in_rs, 15'd0, 6'h08};                   // JR
            5'd8:  enc = {6'h08, in_rs, in_rt, in_imm};                  // ADDI
            5'd9:  enc = {6'h0C, in_rs, in_rt, in_imm};                  // ANDI
            5'd10: enc = {6'h0F, 5'd0, in_rt, in_imm};                   // LUI
            5'd11: enc = {6'h0D, in_rs, in_rt, in_imm};                  // ORI
            5'd12: enc = {6'h23, in_rs, in_rt, in_imm};                  // LW
            5'd13: enc = {6'h2B, in_rs, in_rt, in_imm};                  // SW
            5'd14: enc = {6'h04, in_rs, in_rt, in_imm};                  // BEQ
            5'd15: enc = {6'h05, in_rs, in_rt, in_imm};                  // BNE
            5'd16: enc = {6'h0A, in_rs, in_rt, in_imm};                  // SLTI
            5'd17: enc = {6'h03, in_target};                             // JAL
            5'd18: enc = {6'h02, in_target};                             // J
            default: legal = 1'b0;
        endcase
    end

    assign ptr_inc = ptr_q + PtrOne;

    // Next-state logic; clr overrides every other event.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wdata_d   = wdata_q;
        illegal_d = 1'b0;
        err_d     = err_q;
        if (clr) begin
            state_d = StIdle;
            ptr_d   = '0;
            err_d   = 8'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (legal) begin
                            wdata_d = enc;
                            state_d = StWrite;
                        end else begin
                            illegal_d = 1'b1;
                            if (err_q != 8'hFF) begin
                                err_d = err_q + 8'd1;
                            end
                        end
                    end
                end
                StWrite: begin
                    if (im_ack) begin
                        ptr_d   = ptr_inc;
                        state_d = (ptr_inc == DepthVal) ? StFull : StIdle;
                    end
                end
                StFull:  state_d = StFull;
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            wdata_q   <= 32'h0;
            illegal_q <= 1'b0;
            err_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wdata_q   <= wdata_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign im_we     = (state_q == StWrite);
    assign full      = (state_q == StFull);
    assign im_addr   = ptr_q[ADDR_W-1:0];
    assign im_wdata  = wdata_q;
    assign illegal   = illegal_q;
    assign wr_count  = ptr_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (small DEPTH to reach FULL).
module tb_instr_encoder;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n, clr, in_valid, in_ready, im_we, im_ack, full, illegal;
    logic [4:0]        in_mnem, in_rs, in_rt, in_rd, in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [ADDR_W:0]   wr_count;
    logic [7:0]        err_count;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_ack(im_ack),
        .full(full), .illegal(illegal), .wr_count(wr_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh,
                           input logic [15:0] imm, input logic [25:0] tg);
        in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_target = tg; in_valid = 1'b1;
    endtask

    // Present the held request until the handshake edge, bounded.
    task automatic accept();
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout in_ready got %b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", im_we); end
        checks++; if (im_addr !== 3'd0) begin errors++; $display("FAIL rst_addr got %h exp 0", im_addr); end
        checks++; if (im_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", im_wdata); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", illegal); end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL rst_wr_count got %0d exp 0", wr_count); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count got %0d exp 0", err_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_basic();
        im_ack = 1'b1;
        set_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        accept();
        checks++; if (im_we !== 1'b1) begin errors++; $display("FAIL basic_we got %b exp 1", im_we); end
        checks++; if (im_addr !== 3'd0) begin errors++; $display("FAIL basic_addr0 got %h exp 0", im_addr); end
        checks++; if (im_wdata !== 32'h00221821) begin errors++; $display("FAIL basic_addu got %h exp 00221821", im_wdata); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", in_ready); end
        tick();
        checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL basic_we_drop got %b exp 0", im_we); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", in_ready); end
        checks++; if (wr_count !== 4'd1) begin errors++; $display("FAIL basic_cnt1 got %0d exp 1", wr_count); end
        set_req(5'd11, 5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0);
        accept();
        checks++; if (im_addr !== 3'd1) begin errors++; $display("FAIL basic_addr1 got %h exp 1", im_addr); end
        checks++; if (im_wdata !== 32'h34081234) begin errors++; $display("FAIL basic_ori got %h exp 34081234", im_wdata); end
        tick();
        checks++; if (wr_count !== 4'd2) begin errors++; $display("FAIL basic_cnt2 got %0d exp 2", wr_count); end
    endtask

    task automatic test_encodings();
        logic [4:0]  m[9]  = '{5'd12, 5'd6, 5'd7, 5'd10, 5'd18, 5'd13, 5'd15, 5'd17, 5'd5};
        logic [4:0]  rs[9] = '{5'd29, 5'd7, 5'd31, 5'd4, 5'd1, 5'd4, 5'd1, 5'd9, 5'd1};
        logic [4:0]  rt[9] = '{5'd9, 5'd3, 5'd5, 5'd1, 5'd2, 5'd5, 5'd2, 5'd9, 5'd2};
        logic [4:0]  rd[9] = '{5'd7, 5'd2, 5'd6, 5'd3, 5'd3, 5'd1, 5'd1, 5'd9, 5'd3};
        logic [4:0]  sh[9] = '{5'd1, 5'd4, 5'd3, 5'd2, 5'd2, 5'd1, 5'd1, 5'd9, 5'd5};
        logic [15:0] im[9] = '{16'h0004, 16'h1111, 16'h2222, 16'h1001, 16'h3333,
                               16'h0008, 16'hFFFE, 16'h4444, 16'h5555};
        logic [25:0] tg[9] = '{26'h1, 26'h1, 26'h1, 26'h1, 26'h40, 26'h1, 26'h1,
                               26'h3FFFFFF, 26'h1};
        logic [31:0] ex[9] = '{32'h8FA90004, 32'h00031102, 32'h03E00008, 32'h3C011001,
                               32'h08000040, 32'hAC850008, 32'h1422FFFE, 32'h0FFFFFFF,
                               32'h00221827};
        for (int i = 0; i < 9; i++) begin
            pulse_clr();
            set_req(m[i], rs[i], rt[i], rd[i], sh[i], im[i], tg[i]);
            accept();
            checks++;
            if (im_wdata !== ex[i]) begin
                errors++;
                $display("FAIL enc_%0d mnem %0d got %h exp %h", i, m[i], im_wdata, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_ack_wait();
        pulse_clr();
        im_ack = 1'b0;
        set_req(5'd8, 5'd2, 5'd3, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        accept();
        for (int i = 0; i < 4; i++) begin
            checks++; if (im_we !== 1'b1) begin errors++; $display("FAIL wait_we_%0d got %b exp 1", i, im_we); end
            checks++; if (im_wdata !== 32'h2043FFFF) begin errors++; $display("FAIL wait_wdata_%0d got %h exp 2043ffff", i, im_wdata); end
            checks++; if (im_addr !== 3'd0) begin errors++; $display("FAIL wait_addr_%0d got %h exp 0", i, im_addr); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wait_ready_%0d got %b exp 0", i, in_ready); end
            checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL wait_cnt_%0d got %0d exp 0", i, wr_count); end
            if (i == 3) im_ack = 1'b1;
            tick();
        end
        checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL wait_done_we got %b exp 0", im_we); end
        checks++; if (wr_count !== 4'd1) begin errors++; $display("FAIL wait_done_cnt got %0d exp 1", wr_count); end
    endtask

    task automatic test_illegal();
        pulse_clr();
        set_req(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
        accept();
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_pulse got %b exp 1", illegal); end
        checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL ill_we got %b exp 0", im_we); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL ill_err1 got %0d exp 1", err_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got %b exp 1", in_ready); end
        tick();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_one_cycle got %b exp 0", illegal); end
        in_valid = 1'b1;
        repeat (300) tick();
        in_valid = 1'b0;
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL ill_sat got %0d exp 255", err_count); end
        tick();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_end got %b exp 0", illegal); end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL ill_cnt got %0d exp 0", wr_count); end
    endtask

    task automatic test_full();
        pulse_clr();
        im_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(5'd4, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 16'h0, 26'h0);
            accept();
            tick();
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", in_ready); end
        checks++; if (wr_count !== 4'd4) begin errors++; $display("FAIL full_cnt got %0d exp 4", wr_count); end
        set_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        repeat (3) tick();
        checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL full_5th_we got %b exp 0", im_we); end
        checks++; if (wr_count !== 4'd4) begin errors++; $display("FAIL full_5th_cnt got %0d exp 4", wr_count); end
        pulse_clr();
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_clr got %b exp 0", full); end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL full_clr_cnt got %0d exp 0", wr_count); end
        checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL full_clr_we got %b exp 0", im_we); end
        accept();
        checks++; if (im_addr !== 3'd0) begin errors++; $display("FAIL full_next_addr got %h exp 0", im_addr); end
        checks++; if (im_wdata !== 32'h00221821) begin errors++; $display("FAIL full_next_wdata got %h exp 00221821", im_wdata); end
        tick();
    endtask

    task automatic test_clr_mid_write();
        pulse_clr();
        im_ack = 1'b1;
        set_req(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        accept();
        tick();
        im_ack = 1'b0;
        set_req(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        accept();
        checks++; if (im_addr !== 3'd1) begin errors++; $display("FAIL clrw_addr got %h exp 1", im_addr); end
        pulse_clr();
        checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL clrw_we got %b exp 0", im_we); end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL clrw_cnt got %0d exp 0", wr_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clrw_ready got %b exp 1", in_ready); end
        // Illegal and legal requests coincident with clr are both dropped.
        set_req(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        pulse_clr();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL clrw_ill got %b exp 0", illegal); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clrw_err got %0d exp 0", err_count); end
        set_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        pulse_clr();
        in_valid = 1'b0;
        checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL clrw_req_we got %b exp 0", im_we); end
        im_ack = 1'b1;
        set_req(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        accept();
        checks++; if (im_addr !== 3'd0) begin errors++; $display("FAIL clrw_next_addr got %h exp 0", im_addr); end
        checks++; if (im_wdata !== 32'h00221824) begin errors++; $display("FAIL clrw_next_and got %h exp 00221824", im_wdata); end
        tick();
    endtask

    task automatic test_rst_mid_write();
        pulse_clr();
        im_ack = 1'b1;
        set_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        accept();
        tick();
        im_ack = 1'b0;
        set_req(5'd16, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0010, 26'h0);
        accept();
        checks++; if (im_we !== 1'b1) begin errors++; $display("FAIL rstw_we_pre got %b exp 1", im_we); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL rstw_we got %b exp 0", im_we); end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL rstw_cnt got %0d exp 0", wr_count); end
        checks++; if (im_addr !== 3'd0) begin errors++; $display("FAIL rstw_addr got %h exp 0", im_addr); end
        tick();
        rst_n = 1'b1;
        im_ack = 1'b1;
        set_req(5'd16, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0010, 26'h0);
        accept();
        checks++; if (im_addr !== 3'd0) begin errors++; $display("FAIL rstw_next_addr got %h exp 0", im_addr); end
        checks++; if (im_wdata !== 32'h28850010) begin errors++; $display("FAIL rstw_slti got %h exp 28850010", im_wdata); end
        tick();
        checks++; if (wr_count !== 4'd1) begin errors++; $display("FAIL rstw_cnt1 got %0d exp 1", wr_count); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; im_ack = 1'b1;
        in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_imm = '0; in_target = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_encodings();
        test_ack_wait();
        test_illegal();
        test_full();
        test_clr_mid_write();
        test_rst_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
